// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit sides.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic PARITY_EVEN = 1'b1;
  localparam logic PARITY_ODD  = 1'b0;

endpackage

// File: rtl/uart_rx_if.sv
// Received-word delivery bundle from the UART receiver to downstream logic.
interface uart_rx_if #(
  parameter int N = 8
);
  logic [N-1:0] data_out;
  logic         data_valid;
  logic         parity_err;
  logic         frame_err;
  logic         busy;

  modport master (
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err,
    output busy
  );

  modport slave (
    input data_out,
    input data_valid,
    input parity_err,
    input frame_err,
    input busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start detect, mid-bit sampling, LSB-first
// deserialisation, optional parity check and stop-bit check.
//
// state  | meaning
// IDLE   | waiting for the synchronised line to go low
// START  | counting to mid start bit; confirm or reject as glitch
// DATA   | sampling N data bits, one per OVERSAMPLE ticks
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit; result published, back to IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int N          = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       sample_tick,
  input  logic       parity_en,
  input  logic       parity_type_even_odd,
  input  logic       Rx_in,
  uart_rx_if.master  rx_if
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(N - 1);

  rx_state_t     state, state_nxt;
  logic          rx_s;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic [N-1:0]  shift_reg;
  logic          parity_bit;
  logic          break_hold;
  logic [N-1:0]  data_q;
  logic          valid_q, parity_err_q, frame_err_q;

  logic tick_clr, tick_inc, bit_clr, bit_inc, shift_en, par_cap, stop_cap;
  logic tick_end;

  uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (Rx_in),
    .q      (rx_s)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tick_clr  = 1'b0;
    tick_inc  = 1'b0;
    bit_clr   = 1'b0;
    bit_inc   = 1'b0;
    shift_en  = 1'b0;
    par_cap   = 1'b0;
    stop_cap  = 1'b0;
    tick_end  = (tick_cnt == T_END);
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          tick_clr  = 1'b1;
        end
      end
      START: begin
        if (sample_tick) begin
          if (tick_cnt == T_MID) begin
            tick_clr = 1'b1;
            bit_clr  = 1'b1;
            // a held-low line after a framing error is a break, not a new start
            state_nxt = (!rx_s && !break_hold) ? DATA : IDLE;
          end else begin
            tick_inc = 1'b1;
          end
        end
      end
      DATA: begin
        if (sample_tick) begin
          if (tick_end) begin
            shift_en = 1'b1;
            tick_clr = 1'b1;
            if (bit_cnt == B_LAST) state_nxt = parity_en ? PARITY : STOP;
            else                   bit_inc   = 1'b1;
          end else begin
            tick_inc = 1'b1;
          end
        end
      end
      PARITY: begin
        if (sample_tick) begin
          if (tick_end) begin
            par_cap   = 1'b1;
            tick_clr  = 1'b1;
            state_nxt = STOP;
          end else begin
            tick_inc = 1'b1;
          end
        end
      end
      STOP: begin
        if (sample_tick) begin
          if (tick_end) begin
            stop_cap  = 1'b1;
            tick_clr  = 1'b1;
            state_nxt = IDLE;
          end else begin
            tick_inc = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      parity_bit   <= 1'b0;
      break_hold   <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (tick_clr)      tick_cnt <= '0;
      else if (tick_inc) tick_cnt <= tick_cnt + 1'b1;
      if (bit_clr)       bit_cnt <= '0;
      else if (bit_inc)  bit_cnt <= bit_cnt + 1'b1;
      if (shift_en) shift_reg  <= {rx_s, shift_reg[N-1:1]};
      if (par_cap)  parity_bit <= rx_s;
      if (stop_cap)  break_hold <= ~rx_s;
      else if (rx_s) break_hold <= 1'b0;
      if (stop_cap) begin
        data_q       <= shift_reg;
        valid_q      <= 1'b1;
        frame_err_q  <= ~rx_s;
        parity_err_q <= parity_en & ((^{shift_reg, parity_bit}) != ~parity_type_even_odd);
      end
    end
  end

  assign rx_if.data_out   = data_q;
  assign rx_if.data_valid = valid_q;
  assign rx_if.parity_err = parity_err_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.busy       = (state != IDLE);

endmodule
